// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-read-port register file with two write ports, hardwired
//             zero register, post-reset clear sweep and a registered flag for
//             same-address dual writes.
//  Ports    : clk, rst (sync, active-high)
//             we1/waddr1/wdata1, we2/waddr2/wdata2 : write ports (2 wins)
//             raddr [NRP*AW]  : packed read addresses, port k at [k*AW +: AW]
//             rdata [NRP*XLEN]: packed read data,      port k at [k*XLEN +: XLEN]
//             busy            : high while the clear sweep runs
//             wr_conflict     : one-cycle flag after a same-address dual write
//  Config   : define REGFILE_MP_BYPASS_EN to forward same-cycle write data
//             to matching read ports.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we1,
    input  logic [$clog2(NREG)-1:0] waddr1,
    input  logic [XLEN-1:0]        wdata1,
    input  logic                   we2,
    input  logic [$clog2(NREG)-1:0] waddr2,
    input  logic [XLEN-1:0]        wdata2,
    input  logic [NRP*$clog2(NREG)-1:0] raddr,
    output logic [NRP*XLEN-1:0]    rdata,
    output logic                   busy,
    output logic                   wr_conflict
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] c_ONE      = AW'(1);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREG - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic            r_wr_conflict;
    logic [XLEN-1:0] r_mem [NREG];

    logic w_busy;
    logic w_we1_ok;
    logic w_we2_ok;
    logic w_conflict;

    assign w_busy   = (r_state == S_CLEAR);
    // Address 0 is hardwired, so a write there is simply never accepted.
    assign w_we1_ok = we1 && !w_busy && (waddr1 != '0);
    assign w_we2_ok = we2 && !w_busy && (waddr2 != '0);
    assign w_conflict = w_we1_ok && w_we2_ok && (waddr1 == waddr2);

    // ------------------------------------------------------------------
    // Control FSM: CLEAR sweeps every entry once, then RUN until reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == c_LAST_IDX) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_CLEAR;
            r_clr_idx     <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            if (r_state == S_CLEAR) begin
                r_clr_idx <= r_clr_idx + c_ONE;
            end
            r_wr_conflict <= w_conflict;
        end
    end

    // ------------------------------------------------------------------
    // Storage. The sweep owns the array while busy; afterwards port 2 is
    // written last so it wins a same-address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_busy) begin
            if (!rst) begin
                r_mem[r_clr_idx] <= '0;
            end
        end else begin
            if (w_we1_ok) r_mem[waddr1] <= wdata1;
            if (w_we2_ok) r_mem[waddr2] <= wdata2;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rv;

        assign w_ra = raddr[k*AW +: AW];

        always_comb begin
            w_rv = r_mem[w_ra];
`ifdef REGFILE_MP_BYPASS_EN
            if (w_we2_ok && (waddr2 == w_ra)) begin
                w_rv = wdata2;
            end else if (w_we1_ok && (waddr1 == w_ra)) begin
                w_rv = wdata1;
            end
`else
            // Without forwarding the pre-edge stored value is returned.
`endif
            if (w_busy || (w_ra == '0)) begin
                w_rv = '0;
            end
        end

        assign rdata[k*XLEN +: XLEN] = w_rv;
    end

    assign busy        = w_busy;
    assign wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. A default-size instance is
//             compared every cycle against an array-based model; a small
//             XLEN=16/NREG=8/NRP=3 instance gets directed checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    localparam int XB = 16;
    localparam int NB = 8;
    localparam int PB = 3;
    localparam int AB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic                rst = 1'b1;
    logic                we1 = 1'b0, we2 = 1'b0;
    logic [AW-1:0]       waddr1 = '0, waddr2 = '0;
    logic [XLEN-1:0]     wdata1 = '0, wdata2 = '0;
    logic [NRP*AW-1:0]   raddr = '0;
    logic [NRP*XLEN-1:0] rdata;
    logic                busy, wr_conflict;

    // Small instance
    logic               rst_b = 1'b1;
    logic               we1_b = 1'b0, we2_b = 1'b0;
    logic [AB-1:0]      waddr1_b = '0, waddr2_b = '0;
    logic [XB-1:0]      wdata1_b = '0, wdata2_b = '0;
    logic [PB*AB-1:0]   raddr_b = '0;
    logic [PB*XB-1:0]   rdata_b;
    logic               busy_b, wr_conflict_b;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk(clk), .rst(rst),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
        .raddr(raddr), .rdata(rdata),
        .busy(busy), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.XLEN(XB), .NREG(NB), .NRP(PB)) dut_b (
        .clk(clk), .rst(rst_b),
        .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
        .we2(we2_b), .waddr2(waddr2_b), .wdata2(wdata2_b),
        .raddr(raddr_b), .rdata(rdata_b),
        .busy(busy_b), .wr_conflict(wr_conflict_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: "since" counts clean cycles after reset; the
    // register file is busy until NREG of them have elapsed, at which point
    // every entry is known to be zero.
    // ------------------------------------------------------------------
    int              since  = NREG;
    bit              mon_en = 1'b0;
    bit              mdl_conf = 1'b0;
    logic            mdl_busy;
    logic [XLEN-1:0] mdl [NREG];

    always @(posedge clk) begin
        mdl_busy = (since < NREG);
        if (!mdl_busy) begin
            if (we1 && waddr1 != 0) mdl[waddr1] = wdata1;
            if (we2 && waddr2 != 0) mdl[waddr2] = wdata2;
        end
        mdl_conf = !rst && !mdl_busy && we1 && we2 && (waddr1 == waddr2) && (waddr1 != 0);
        if (rst) begin
            since  = 0;
            mon_en = 1'b1;
        end else if (since < NREG) begin
            since++;
            if (since == NREG) begin
                for (int i = 0; i < NREG; i++) mdl[i] = '0;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (since < NREG) return '0;
        if (a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (we2 && waddr2 == a) return wdata2;
        if (we1 && waddr1 == a) return wdata1;
`endif
        return mdl[a];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_busy", busy, (since < NREG));
            chk("mon_wr_conflict", wr_conflict, mdl_conf);
            for (int k = 0; k < NRP; k++) begin
                chk($sformatf("mon_rdata%0d", k), rdata[k*XLEN +: XLEN], exp_rd(raddr[k*AW +: AW]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
    endtask

    int cnt;
    logic [XLEN-1:0] same_cycle_exp;

    initial begin
        // Reset for one cycle, then measure the sweep.
        tick();
        rst   = 1'b0;
        rst_b = 1'b0;
        count_busy(cnt);
        chk("busy_len_after_reset", cnt, 32);
        chk("conflict_idle", wr_conflict, 1'b0);
        for (int a = 0; a < NREG; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            chk("post_sweep_p0", rdata[0 +: XLEN], 32'h0);
            chk("post_sweep_p1", rdata[XLEN +: XLEN], 32'h0);
        end

        // Same-address dual write: port 2 wins, flag for one cycle.
        tick();
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF;
        we2 = 1'b1; waddr2 = 5'd5; wdata2 = 32'h12345678;
        raddr = {5'd0, 5'd5};
        tick();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("dual_write_reg5", rdata[0 +: XLEN], 32'h12345678);
        chk("conflict_set", wr_conflict, 1'b1);
        tick();
        chk("conflict_one_cycle", wr_conflict, 1'b0);

        // Write to register 0 is discarded.
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
        raddr = {5'd0, 5'd0};
        tick();
        we1 = 1'b0;
        #1;
        chk("reg0_p0", rdata[0 +: XLEN], 32'h0);
        chk("reg0_p1", rdata[XLEN +: XLEN], 32'h0);

        // Same-cycle read of a register being written.
        we2 = 1'b1; waddr2 = 5'd7; wdata2 = 32'hA5A5A5A5;
        raddr = {5'd7, 5'd0};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        same_cycle_exp = 32'hA5A5A5A5;
`else
        same_cycle_exp = 32'h0;
`endif
        chk("same_cycle_read7", rdata[XLEN +: XLEN], same_cycle_exp);
        tick();
        we2 = 1'b0;
        #1;
        chk("next_cycle_read7", rdata[XLEN +: XLEN], 32'hA5A5A5A5);

        // Reset mid-sweep at index 10, with writes attempted during the sweep.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("busy_mid_sweep", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h33333333;
        count_busy(cnt);
        we1 = 1'b0;
        chk("busy_len_after_restart", cnt, 32);
        raddr = {5'd0, 5'd3};
        #1;
        chk("reg3_write_ignored", rdata[0 +: XLEN], 32'h0);

        // Randomized traffic; the monitor compares every cycle.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst    = ($urandom_range(0, 299) == 0);
            we1    = $urandom_range(0, 1);
            we2    = $urandom_range(0, 1);
            waddr1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            waddr2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wdata1 = $urandom;
            wdata2 = $urandom;
            for (int k = 0; k < NRP; k++) begin
                case ($urandom_range(0, 3))
                    0:       raddr[k*AW +: AW] = waddr1;
                    1:       raddr[k*AW +: AW] = waddr2;
                    default: raddr[k*AW +: AW] = AW'($urandom);
                endcase
            end
        end
        tick();
        rst = 1'b0; we1 = 1'b0; we2 = 1'b0;

        // Small configuration: XLEN=16, NREG=8, NRP=3.
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("b_sweep_done", busy_b, 1'b0);
        we1_b = 1'b1; waddr1_b = 3'd1; wdata1_b = 16'h00FF;
        we2_b = 1'b1; waddr2_b = 3'd2; wdata2_b = 16'hABCD;
        tick();
        we1_b = 1'b0; we2_b = 1'b0;
        raddr_b = {3'd0, 3'd2, 3'd1};
        #1;
        chk("b_rdata0", rdata_b[0 +: XB], 16'h00FF);
        chk("b_rdata1", rdata_b[XB +: XB], 16'hABCD);
        chk("b_rdata2", rdata_b[2*XB +: XB], 16'h0000);
        chk("b_no_conflict", wr_conflict_b, 1'b0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits (8..64).
REQ-002 SHALL provide parameter NREG, default 32, register count (power of 2, 4..64); AW = clog2(NREG) is a derived localparam.
REQ-003 SHALL provide parameter NRP, default 2, read port count (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port we1  input  1  write enable, port 1.
REQ-007 SHALL have port waddr1  input  AW  write address, port 1.
REQ-008 SHALL have port wdata1  input  XLEN  write data, port 1.
REQ-009 SHALL have port we2  input  1  write enable, port 2.
REQ-010 SHALL have port waddr2  input  AW  write address, port 2.
REQ-011 SHALL have port wdata2  input  XLEN  write data, port 2.
REQ-012 SHALL have port raddr  input  NRP*AW  packed read addresses; port k at bits [k*AW +: AW].
REQ-013 SHALL have port rdata  output  NRP*XLEN  packed read data; port k at bits [k*XLEN +: XLEN].
REQ-014 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-015 SHALL have port wr_conflict  output  1  registered one-cycle flag for a same-address dual write.

Function
REQ-016 SHALL hardwire register 0: writes to address 0 are discarded and reads of address 0 return 0.
REQ-017 SHALL perform writes on the rising edge of clk when weN=1, busy=0 and waddrN!=0.
REQ-018 SHALL, when both ports write the same nonzero address in one cycle, store wdata2 (port 2 has priority).
REQ-019 SHALL assert wr_conflict for exactly the cycle after a REQ-018 event and deassert it otherwise; writes to different addresses in one cycle both take effect.
REQ-020 SHALL provide combinational reads: rdata port k reflects raddr port k in the same cycle.
REQ-021 SHALL drive all rdata to 0 while busy=1.
REQ-022 SHALL implement FSM states CLEAR and RUN. CLEAR writes 0 to entry clr_idx each cycle, clr_idx counting 0..NREG-1. After clearing entry NREG-1 the FSM goes to RUN on the next edge. RUN has no exit except rst.
REQ-023 SHALL hold busy=1 exactly in CLEAR, i.e. for NREG cycles after rst deasserts.
REQ-024 SHALL ignore we1/we2 while busy=1; no write, no conflict flag.

Reset
REQ-025 SHALL, while rst=1 on a clk edge, set state=CLEAR, clr_idx=0, busy=1, wr_conflict=0.
REQ-026 SHALL restart the clear sweep at index 0 when rst is asserted mid-sweep or in RUN.
REQ-027 SHALL leave array contents unspecified until the sweep completes; no output depends on them before busy falls.

Configuration
REQ-028 SHALL honour macro REGFILE_MP_BYPASS_EN. When defined, a read whose address matches a same-cycle accepted write (REQ-017) returns that write data, with port 2 data on a same-address conflict. Address 0 and busy=1 still force 0.
REQ-029 SHALL, without REGFILE_MP_BYPASS_EN, return the pre-edge stored value on such a read; the new value is visible the cycle after the write.

Verification
REQ-030 SHALL cover: rst high 1 cycle, then low -> busy=1 for exactly 32 cycles; every read returns 0 after busy falls; wr_conflict=0 throughout.
REQ-031 SHALL cover: we1=1, waddr1=5, wdata1=0xDEADBEEF, plus we2=1, waddr2=5, wdata2=0x12345678 -> reg5 reads 0x12345678 next cycle; wr_conflict=1 for one cycle.
REQ-032 SHALL cover: we1=1, waddr1=0, wdata1=0xFFFFFFFF -> raddr=0 reads 0 on all ports.
REQ-033 SHALL cover: we2=1, waddr2=7, wdata2=0xA5A5A5A5 with raddr port1=7 in the same cycle -> same-cycle rdata is 0xA5A5A5A5 with BYPASS_EN, previous value without; next cycle 0xA5A5A5A5 in both builds.
REQ-034 SHALL cover: rst asserted at clear index 10 -> busy stays 1 for another full 32 cycles; we1=1, waddr1=3 during clear -> reg3 reads 0 after busy falls.
REQ-035 SHALL cover: XLEN=16, NREG=8, NRP=3; write 0x00FF to reg1 and 0xABCD to reg2; read addresses {1,2,0} -> rdata {0x00FF, 0xABCD, 0x0000}.
